lsu_ctrl: RTL and testbench

// Memory-stage load/store controller between the EX/MEM pipeline register and data_memory.

---
 rtl/lsu_ctrl.sv | 146 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: memory-stage load/store controller between EX/MEM and data_memory
//
// Forms the effective address, checks funct3 legality, alignment and access range,
// sequences data_memory's one-cycle registered read, routes UART_ADDR traffic to the
// UART TX handshake and stalls the pipeline until the access has completed.
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   flush                           pipeline flush; cancels pending loads / UART bytes
//   req_valid, req_is_load/store    memory op present in EX/MEM
//   req_funct3                      RV32I width/sign selector
//   req_base, req_offset            rs1 and sign-extended immediate
//   req_wdata, req_rd               store data, load destination
//   mem_read_en, mem_write_en       one-cycle strobes to data_memory
//   load_type, store_type           funct3 forwarded to data_memory
//   ram_address, data_in            byte address and store data to data_memory
//   send_to_uart                    high while the op targets UART_ADDR
//   mem_data_out                    registered read data from data_memory
//   uart_tx_ready/valid/data        UART TX byte handshake
//   lsu_stall                       combinational hold for IF/ID/EX
//   wb_valid, wb_rd, wb_data        one-cycle load writeback
//   lsu_exc, exc_cause, exc_addr    one-cycle fault report (01 misaligned, 10 access, 11 funct3)
module lsu_ctrl #(
    parameter logic [31:0] UART_ADDR     = 32'hFFFF_0000,
    parameter int          RAM_ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [2:0]  load_type,
    output logic [2:0]  store_type,
    output logic [31:0] ram_address,
    output logic [31:0] data_in,
    output logic        send_to_uart,
    input  logic [31:0] mem_data_out,
    input  logic        uart_tx_ready,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    output logic        lsu_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_exc,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, UART_WAIT} state_t;
    state_t state;
    logic uart_ld;
    logic [31:0] ea;
    logic is_half, is_word, illegal, misaligned, is_uart, access_fault, op;
    logic [1:0] cause;
    always_comb begin
        ea = req_base + req_offset;
        is_half = req_funct3[1:0] == 2'b01;
        is_word = req_funct3[1:0] == 2'b10;
        // loads allow 000,001,010,100,101; stores allow 000,001,010
        illegal = req_is_load ? (req_funct3[1:0] == 2'b11 || req_funct3[2:1] == 2'b11)
                              : (req_funct3[2] || req_funct3[1:0] == 2'b11);
        misaligned = (is_half && ea[0]) || (is_word && ea[1:0] != 2'b00);
        is_uart = ea == UART_ADDR;
        // only sb (transmit) and lw (status poll) are meaningful at the UART register
        access_fault = is_uart ? !((req_is_store && req_funct3 == 3'b000) ||
                                   (req_is_load && req_funct3 == 3'b010))
                               : |ea[31:RAM_ADDR_BITS];
        cause = illegal ? 2'b11 : misaligned ? 2'b01 : access_fault ? 2'b10 : 2'b00;
        op = state == IDLE && req_valid && !flush && (req_is_load || req_is_store);
        lsu_stall = state != IDLE || (op && cause == 2'b00);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            uart_ld <= 1'b0;
            mem_read_en <= 1'b0;
            mem_write_en <= 1'b0;
            load_type <= 3'b000;
            store_type <= 3'b000;
            ram_address <= 32'h0;
            data_in <= 32'h0;
            send_to_uart <= 1'b0;
            uart_tx_valid <= 1'b0;
            uart_tx_data <= 8'h0;
            wb_valid <= 1'b0;
            wb_rd <= 5'h0;
            wb_data <= 32'h0;
            lsu_exc <= 1'b0;
            exc_cause <= 2'b00;
            exc_addr <= 32'h0;
        end else begin
            mem_read_en <= 1'b0;
            mem_write_en <= 1'b0;
            wb_valid <= 1'b0;
            lsu_exc <= 1'b0;
            case (state)
                IDLE: if (op) begin
                    if (cause != 2'b00) begin
                        lsu_exc <= 1'b1;
                        exc_cause <= cause;
                        exc_addr <= ea;
                    end else begin
                        ram_address <= ea;
                        load_type <= req_funct3;
                        store_type <= req_funct3;
                        data_in <= req_wdata;
                        wb_rd <= req_rd;
                        uart_tx_data <= req_wdata[7:0];
                        uart_ld <= is_uart && req_is_load;
                        if (is_uart) begin
                            send_to_uart <= 1'b1;
                            uart_tx_valid <= req_is_store;
                            state <= req_is_load ? RESP : UART_WAIT;
                        end else begin
                            mem_read_en <= req_is_load;
                            mem_write_en <= req_is_store;
                            state <= ISSUE;
                        end
                    end
                end
                // the strobe issued on entry already reached memory; flush only drops the load
                ISSUE: state <= (mem_read_en && !flush) ? RESP : IDLE;
                RESP: begin
                    if (!flush) wb_data <= uart_ld ? {31'b0, uart_tx_ready} : mem_data_out;
                    wb_valid <= !flush;
                    send_to_uart <= 1'b0;
                    state <= IDLE;
                end
                UART_WAIT: if (flush || uart_tx_ready) begin
                    uart_tx_valid <= 1'b0;
                    send_to_uart <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and random load/store transactions checked against a transaction-level model
module tb_lsu_ctrl;
    localparam logic [31:0] UART = 32'hFFFF_0000;
    localparam int W = 10;
    logic clk = 1'b0;
    logic reset, flush, req_valid, req_is_load, req_is_store;
    logic [2:0] req_funct3;
    logic [31:0] req_base, req_offset, req_wdata;
    logic [4:0] req_rd;
    logic mem_read_en, mem_write_en, send_to_uart, uart_tx_ready, uart_tx_valid;
    logic [2:0] load_type, store_type;
    logic [31:0] ram_address, data_in, mem_data_out, wb_data, exc_addr;
    logic [7:0] uart_tx_data;
    logic lsu_stall, wb_valid, lsu_exc;
    logic [4:0] wb_rd;
    logic [1:0] exc_cause;
    logic [7:0] mem [4096];
    logic [7:0] ref_mem [4096];
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
        .req_is_load(req_is_load), .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .load_type(load_type),
        .store_type(store_type), .ram_address(ram_address), .data_in(data_in),
        .send_to_uart(send_to_uart), .mem_data_out(mem_data_out), .uart_tx_ready(uart_tx_ready),
        .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .lsu_stall(lsu_stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .lsu_exc(lsu_exc),
        .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] o, input logic [2:0] f3);
        logic [31:0] s;
        s = w >> {o, 3'b000};
        case (f3)
            3'b000: return {{24{s[7]}}, s[7:0]};
            3'b001: return {{16{s[15]}}, s[15:0]};
            3'b100: return {24'b0, s[7:0]};
            3'b101: return {16'b0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // data_memory stand-in: byte-addressed RAM with a one-cycle registered read
    always @(posedge clk) begin
        int a;
        a = int'(ram_address[11:0]);
        if (mem_write_en)
            for (int i = 0; i < (store_type[1:0] == 2'b00 ? 1 : store_type[1:0] == 2'b01 ? 2 : 4); i++)
                mem[(a + i) & 4095] = data_in[8*i +: 8];
        if (mem_read_en) begin
            a = a & ~3;
            mem_data_out <= extract({mem[a+3], mem[a+2], mem[a+1], mem[a]}, ram_address[1:0], load_type);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".read_en"}, 32'(mem_read_en), 0);
        chk({tag, ".write_en"}, 32'(mem_write_en), 0);
        chk({tag, ".load_type"}, 32'(load_type), 0);
        chk({tag, ".store_type"}, 32'(store_type), 0);
        chk({tag, ".ram_address"}, ram_address, 0);
        chk({tag, ".data_in"}, data_in, 0);
        chk({tag, ".send_to_uart"}, 32'(send_to_uart), 0);
        chk({tag, ".tx_valid"}, 32'(uart_tx_valid), 0);
        chk({tag, ".tx_data"}, 32'(uart_tx_data), 0);
        chk({tag, ".stall"}, 32'(lsu_stall), 0);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 0);
        chk({tag, ".wb_rd"}, 32'(wb_rd), 0);
        chk({tag, ".wb_data"}, wb_data, 0);
        chk({tag, ".exc"}, 32'(lsu_exc), 0);
        chk({tag, ".exc_cause"}, 32'(exc_cause), 0);
        chk({tag, ".exc_addr"}, exc_addr, 0);
    endtask

    // One transaction: d = cycles UART keeps ready low, rbit = ready level otherwise,
    // fk = cycle (0 = request cycle) in which flush is raised, -1 for none.
    task automatic run_op(input string tag, input bit ld, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                          input int d, input bit rbit, input int fk);
        logic [31:0] ea, e_data, rd_addr, wr_addr, wr_data, wbd, ex_addr;
        logic [2:0] rd_t, wr_t;
        logic [4:0] wbr;
        logic [1:0] cause, ex_c;
        logic [7:0] txd;
        bit uart, illegal, mis, acc, tx_unstable;
        int sz, fl, a, e_stall, e_rd, e_wr, e_wb, e_exc, e_tx, e_stu;
        int stall_n, rd_n, rd_k, wr_n, wr_k, wb_n, wb_k, exc_n, exc_k, tx_n, stu_n, both;
        ea = base + off;
        uart = ea == UART;
        illegal = ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : !(f3 inside {3'd0, 3'd1, 3'd2});
        sz = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
        mis = (int'(ea[1:0]) % sz) != 0;
        acc = uart ? !((!ld && f3 == 3'd0) || (ld && f3 == 3'd2)) : ea >= 32'd4096;
        cause = illegal ? 2'd3 : mis ? 2'd1 : acc ? 2'd2 : 2'd0;
        fl = fk < 0 ? 1000 : fk;
        e_stall = 0; e_rd = -1; e_wr = -1; e_wb = -1; e_exc = -1; e_tx = 0; e_stu = 0; e_data = 0;
        a = int'(ea[11:0]);
        if (fk == 0) begin
        end else if (cause != 2'd0) e_exc = 1;
        else if (uart && ld) begin
            e_stall = 2; e_stu = 1; e_wb = fl > 1 ? 2 : -1; e_data = {31'b0, rbit};
        end else if (uart) begin
            e_tx = fl <= d ? fl : d + 1; e_stall = e_tx + 1; e_stu = e_tx;
        end else if (ld) begin
            e_stall = fl <= 2 ? fl + 1 : 3; e_rd = 1; e_wb = fl <= 2 ? -1 : 3;
            e_data = extract({ref_mem[(a & ~3) + 3], ref_mem[(a & ~3) + 2], ref_mem[(a & ~3) + 1], ref_mem[a & ~3]}, ea[1:0], f3);
        end else begin
            e_stall = 2; e_wr = 1;
            for (int i = 0; i < sz; i++) ref_mem[a + i] = wd[8*i +: 8];
        end
        stall_n = 0; rd_n = 0; rd_k = -1; wr_n = 0; wr_k = -1; wb_n = 0; wb_k = -1;
        exc_n = 0; exc_k = -1; tx_n = 0; stu_n = 0; both = 0; tx_unstable = 0;
        rd_addr = 0; rd_t = 0; wr_addr = 0; wr_data = 0; wr_t = 0; wbd = 0; wbr = 0; ex_addr = 0; ex_c = 0; txd = 0;
        req_is_load = ld; req_is_store = !ld; req_funct3 = f3; req_base = base; req_offset = off;
        req_wdata = wd; req_rd = rd; req_valid = 1'b1; flush = fk == 0;
        uart_tx_ready = (uart && !ld) ? (d == -1) : rbit;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            if (lsu_stall) stall_n++;
            if (mem_read_en) begin rd_n++; if (rd_k < 0) begin rd_k = k; rd_addr = ram_address; rd_t = load_type; end end
            if (mem_write_en) begin wr_n++; if (wr_k < 0) begin wr_k = k; wr_addr = ram_address; wr_data = data_in; wr_t = store_type; end end
            if (wb_valid) begin wb_n++; if (wb_k < 0) begin wb_k = k; wbd = wb_data; wbr = wb_rd; end end
            if (lsu_exc) begin exc_n++; if (exc_k < 0) begin exc_k = k; ex_c = exc_cause; ex_addr = exc_addr; end end
            if (uart_tx_valid) begin
                if (tx_n == 0) txd = uart_tx_data; else if (uart_tx_data !== txd) tx_unstable = 1;
                tx_n++;
            end
            if (send_to_uart) stu_n++;
            if (wb_valid && lsu_exc) both++;
            @(posedge clk); #1;
            req_valid = 1'b0;
            flush = fk == k + 1;
            uart_tx_ready = (uart && !ld) ? (k + 1 >= d + 1) : rbit;
        end
        chk({tag, ".stall_cycles"}, stall_n, e_stall);
        chk({tag, ".read_pulses"}, rd_n, e_rd >= 0 ? 1 : 0);
        chk({tag, ".read_cycle"}, rd_k, e_rd);
        if (e_rd >= 0) begin
            chk({tag, ".read_addr"}, rd_addr, ea);
            chk({tag, ".load_type"}, 32'(rd_t), 32'(f3));
        end
        chk({tag, ".write_pulses"}, wr_n, e_wr >= 0 ? 1 : 0);
        chk({tag, ".write_cycle"}, wr_k, e_wr);
        if (e_wr >= 0) begin
            chk({tag, ".write_addr"}, wr_addr, ea);
            chk({tag, ".write_data"}, wr_data, wd);
            chk({tag, ".store_type"}, 32'(wr_t), 32'(f3));
        end
        chk({tag, ".wb_pulses"}, wb_n, e_wb >= 0 ? 1 : 0);
        chk({tag, ".wb_cycle"}, wb_k, e_wb);
        if (e_wb >= 0) begin
            chk({tag, ".wb_data"}, wbd, e_data);
            chk({tag, ".wb_rd"}, 32'(wbr), 32'(rd));
        end
        chk({tag, ".exc_pulses"}, exc_n, e_exc >= 0 ? 1 : 0);
        chk({tag, ".exc_cycle"}, exc_k, e_exc);
        if (e_exc >= 0) begin
            chk({tag, ".exc_cause"}, 32'(ex_c), 32'(cause));
            chk({tag, ".exc_addr"}, ex_addr, ea);
        end
        chk({tag, ".tx_cycles"}, tx_n, e_tx);
        if (e_tx > 0) begin
            chk({tag, ".tx_data"}, 32'(txd), 32'(wd[7:0]));
            chk({tag, ".tx_stable"}, 32'(tx_unstable), 0);
        end
        chk({tag, ".send_to_uart_cycles"}, stu_n, e_stu);
        chk({tag, ".wb_exc_overlap"}, both, 0);
    endtask

    initial begin
        logic [31:0] ea, base;
        logic [2:0] f3;
        bit ld;
        int kind;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        {mem[16'h107], mem[16'h106], mem[16'h105], mem[16'h104]} = 32'hDEADBEEF;
        {ref_mem[16'h107], ref_mem[16'h106], ref_mem[16'h105], ref_mem[16'h104]} = 32'hDEADBEEF;
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_funct3 = 3'b0; req_base = 0; req_offset = 0; req_wdata = 0; req_rd = 0; uart_tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("lw_ram", 1, 3'b010, 32'h100, 32'h4, 0, 5'd7, 0, 0, -1);
        run_op("lh_misaligned", 1, 3'b001, 32'h100, 32'h3, 0, 5'd1, 0, 0, -1);
        run_op("lw_misaligned", 1, 3'b010, 32'h100, 32'h2, 0, 5'd1, 0, 0, -1);
        run_op("sb_uart_wait", 0, 3'b000, UART, 32'h0, 32'h41, 5'd0, 5, 0, -1);
        run_op("lw_out_of_range", 1, 3'b010, 32'h2000, 32'h0, 0, 5'd2, 0, 0, -1);
        run_op("load_f3_011", 1, 3'b011, 32'h100, 32'h0, 0, 5'd2, 0, 0, -1);
        run_op("sh_uart", 0, 3'b001, UART, 32'h0, 32'h55, 5'd0, 0, 0, -1);
        run_op("lw_flush_resp", 1, 3'b010, 32'h100, 32'h4, 0, 5'd9, 0, 0, 2);
        run_op("lw_after_flush", 1, 3'b010, 32'h100, 32'h4, 0, 5'd9, 0, 0, -1);
        run_op("lw_flush_issue", 1, 3'b010, 32'h100, 32'h4, 0, 5'd9, 0, 0, 1);
        run_op("sw_flush_issue", 0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 5'd0, 0, 0, 1);
        run_op("lw_after_sw_flush", 1, 3'b010, 32'h200, 32'h0, 0, 5'd3, 0, 0, -1);
        run_op("lw_flush_idle", 1, 3'b010, 32'h100, 32'h4, 0, 5'd4, 0, 0, 0);
        run_op("sb_uart_flush", 0, 3'b000, UART, 32'h0, 32'h77, 5'd0, 4, 0, 2);
        run_op("lw_uart_rdy1", 1, 3'b010, UART, 32'h0, 0, 5'd5, 0, 1, -1);
        run_op("lw_uart_rdy0", 1, 3'b010, UART, 32'h0, 0, 5'd6, 0, 0, -1);
        run_op("sw_wrap", 0, 3'b010, 32'hFFFF_FFF0, 32'h20, 32'h8081_F0F1, 5'd0, 0, 0, -1);
        run_op("lb_wrap", 1, 3'b000, 32'h10, 32'h1, 0, 5'd8, 0, 0, -1);
        run_op("lbu_wrap", 1, 3'b100, 32'h10, 32'h1, 0, 5'd8, 0, 0, -1);
        run_op("lh_wrap", 1, 3'b001, 32'h10, 32'h2, 0, 5'd8, 0, 0, -1);
        run_op("lhu_wrap", 1, 3'b101, 32'h10, 32'h2, 0, 5'd8, 0, 0, -1);

        req_is_load = 1'b0; req_is_store = 1'b1; req_funct3 = 3'b010; req_base = 32'h10;
        req_offset = 0; req_wdata = 32'h12345678; req_rd = 0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid.write_en_in_issue", 32'(mem_write_en), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        {ref_mem[16'h13], ref_mem[16'h12], ref_mem[16'h11], ref_mem[16'h10]} = 32'h12345678;
        run_op("lw_after_rst", 1, 3'b010, 32'h10, 32'h0, 0, 5'd11, 0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? (3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000)) : 3'($urandom_range(0, 2));
            if (kind == 9) f3 = 3'($urandom_range(0, 7));
            ea = 32'($urandom_range(0, 4095));
            if (kind < 4) ea = ea & ~32'h3;
            if (kind == 6 || kind == 7) begin
                ea = UART;
                if (kind == 6) f3 = ld ? 3'b010 : 3'b000;
            end
            if (kind == 8) begin
                ea = ($urandom | 32'h0001_0000) & ~32'h3;
                if (ea == UART) ea = ea + 4;
            end
            base = $urandom;
            run_op("random", ld, f3, base, ea - base, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
